serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial adder controller that sequences one full-adder cell (two `halfadder` instances plus an OR) over WIDTH clock cycles to add two WIDTH-bit operands, LSB first. It is the small sequencer the ALU work needs to reuse a single adder cell instead of a WIDTH-bit ripple chain. It offers a start/busy/done handshake and holds the result until the next operation completes.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2).
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted-start edge.
- b  input  WIDTH  operand B; captured on the accepted-start edge.
- cin  input  1  carry-in; captured on the accepted-start edge.
- soma  output  WIDTH  sum of the last completed operation.
- carry  output  1  carry-out of the last completed operation.
- busy  output  1  high from the accepted-start edge until DONE is entered.
- done  output  1  one-cycle pulse: soma/carry just updated.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → load a, b into shift registers; load cin into the carry flop; clear the bit counter; go to RUN.
  - RUN: each edge does the following, then shifts the operands right:
    - s = a0 ^ b0 ^ c, formed by halfadder(a0,b0) then halfadder(s1,c).
    - c ← carry1 | carry2.
    - s is shifted into the MSB of the internal sum register.
  - RUN: counter increments each edge; after the WIDTH-th RUN edge, go to DONE.
  - DONE: soma ← internal sum register; carry ← carry flop; done=1; the next edge goes to IDLE.
- Arithmetic: {carry, soma} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- Counter width: clog2(WIDTH)+1 bits. The counter never wraps within an operation.
- start while busy or in DONE: ignored, no queuing. The operation in flight is unaffected.
- Changes on a, b or cin after capture: no effect.
- soma/carry change only in the cycle done is high. At all other times they hold the previous result.

## Timing
- Reset values (the edge with rst=1 takes priority over everything):
  - FSM = IDLE.
  - soma = 0, carry = 0, busy = 0, done = 0.
  - Internal shift registers, carry flop and counter = 0.
- Reset mid-RUN or in DONE: the operation is aborted, no done pulse, and the outputs return to the reset values.
- Latency, with start sampled at edge E0:
  - busy goes high after E0.
  - Bits 0..WIDTH-1 are computed on edges E1..E_WIDTH.
  - done is high and soma/carry are valid after E_WIDTH, i.e. WIDTH+1 cycles after the start edge.
  - done falls after E_WIDTH+1.
- busy is low in the DONE cycle.
- Minimum start-to-start spacing: WIDTH+2 cycles. A start held high continuously is accepted at the first IDLE edge after DONE.
- The path from the adder cell to the carry flop is the only combinational path. There are no input-to-output combinational paths.

## Structure
- Shared header `alu_defs.vh` holds:
  - the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH.
- Sub-module: the existing `halfadder` (ports a, b, soma, carry), instantiated twice to form the full-adder cell. Do not create a separate full-adder module.
- Single always block for the FSM, counter and registers. The adder cell is continuous assignments/instances only.

## Test plan
- **Basic add.** WIDTH=8, a=3, b=5, cin=0, start for 1 cycle → busy for 8 cycles. done pulses exactly once, 9 cycles after the start edge. soma=8, carry=0.
- **Carry out and held result.** a=255, b=1, cin=0 → soma=0, carry=1. soma/carry stay held through the next 20 idle cycles.
- **Carry-in.** a=0, b=0, cin=1 → soma=1, carry=0. Then a=255, b=255, cin=1 → soma=255, carry=1.
- **Start ignored while busy.** Pulse start with a=10, b=20. Pulse start again with a=1, b=1 at cycle 3 and in the DONE cycle → one done only, soma=30. The next done occurs only after a new start in IDLE.
- **Reset mid-operation.** rst for 1 cycle during RUN, 4 cycles after start → soma=0, carry=0, busy=0, no done. A following start with a=100, b=27 gives soma=127.
- **Randomized check.** 200 random a, b, cin against the reference model a+b+cin, with start held high → every done matches the model. Start-to-start spacing is exactly WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding,
// default operand width and the bit-counter width helper.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One extra bit above clog2 so the counter can reach WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_halfadder.sv
// Single-bit half adder; two of these plus an OR form the full-adder cell
// that the serial adder controller reuses every cycle.
module halfadder (
    input  logic a,
    input  logic b,
    output logic soma,
    output logic carry
);

    assign soma  = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first through a
// single full-adder cell over WIDTH RUN cycles, with a start/busy/done handshake.
// The result registers hold the last completed sum until the next operation ends.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] soma,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam int              CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] soma_q, soma_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic ha0_s, ha0_c;
    logic bit_s, ha1_c;
    logic cell_cout;

    // Full-adder cell built from two half adders; this feeds the carry flop.
    halfadder u_ha0 (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .soma  (ha0_s),
        .carry (ha0_c)
    );

    halfadder u_ha1 (
        .a     (ha0_s),
        .b     (c_q),
        .soma  (bit_s),
        .carry (ha1_c)
    );

    assign cell_cout = ha0_c | ha1_c;

    // Next-state and datapath update; everything holds unless the state says otherwise.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        soma_d  = soma_q;
        c_d     = c_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    c_d     = cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                c_d    = cell_cout;
                sum_d  = {bit_s, sum_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Publish the finished sum on the same edge that enters DONE,
                    // so soma/carry are already valid while done is high.
                    soma_d  = {bit_s, sum_q[WIDTH-1:1]};
                    carry_d = cell_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            soma_q  <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            soma_q  <= soma_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign soma  = soma_q;
    assign carry = carry_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed handshake scenarios
// followed by randomized operands compared against plain a+b+cin arithmetic.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic [W-1:0] soma;
    logic         carry;
    logic         busy;
    logic         done;

    int total;
    int bad;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_in),
        .b     (b_in),
        .cin   (cin_in),
        .soma  (soma),
        .carry (carry),
        .busy  (busy),
        .done  (done)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Presents one start pulse; returns at the negedge right after the start edge.
    task automatic apply_stimulus(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                  input logic op_cin);
        @(negedge clk);
        a_in   = op_a;
        b_in   = op_b;
        cin_in = op_cin;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Runs one operation and reports when done appeared and how long busy was high.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_cin, output int latency,
                          output int busy_cycles, output logic busy_at_done);
        apply_stimulus(op_a, op_b, op_cin);
        latency     = 1;
        busy_cycles = 0;
        while (!done && latency < 40) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            latency++;
        end
        busy_at_done = busy;
        check_output("op_done_seen", {31'd0, done}, 32'd1);
    endtask

    function automatic int ref_sum(input int x, input int y, input int c);
        return (x + y + c) % (1 << (W + 1));
    endfunction

    initial begin
        int           lat;
        int           bcyc;
        logic         bdone;
        int           done_count;
        int           done_at;
        int           gap;
        int           exp_val;
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;
        logic         r_c;

        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_output("reset_soma", {24'd0, soma}, 32'd0);
        check_output("reset_carry", {31'd0, carry}, 32'd0);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        // Basic add 3 + 5
        run_op(8'd3, 8'd5, 1'b0, lat, bcyc, bdone);
        check_output("basic_latency", lat, W + 1);
        check_output("basic_busy_cycles", bcyc, W);
        check_output("basic_busy_in_done", {31'd0, bdone}, 32'd0);
        check_output("basic_soma", {24'd0, soma}, 32'd8);
        check_output("basic_carry", {31'd0, carry}, 32'd0);
        @(negedge clk);
        check_output("basic_done_pulse_width", {31'd0, done}, 32'd0);

        // Carry out and held result
        run_op(8'd255, 8'd1, 1'b0, lat, bcyc, bdone);
        check_output("cout_result", {23'd0, carry, soma}, 32'd256);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_output("cout_hold", {23'd0, carry, soma}, 32'd256);
            check_output("cout_idle_done", {30'd0, busy, done}, 32'd0);
        end

        // Carry-in cases
        run_op(8'd0, 8'd0, 1'b1, lat, bcyc, bdone);
        check_output("cin_zero_ops", {23'd0, carry, soma}, 32'd1);
        run_op(8'd255, 8'd255, 1'b1, lat, bcyc, bdone);
        check_output("cin_all_ones", {23'd0, carry, soma}, 32'd511);

        // Start ignored while busy and in DONE
        apply_stimulus(8'd10, 8'd20, 1'b0);
        done_count = 0;
        done_at    = 0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 3) begin
                start = 1'b1;
                a_in  = 8'd1;
                b_in  = 8'd1;
            end
            if (k == 4) start = 1'b0;
            if (done_at != 0 && k == done_at + 1) start = 1'b0;
            if (done) begin
                done_count++;
                if (done_at == 0) done_at = k;
                start = 1'b1;
                a_in  = 8'd1;
                b_in  = 8'd1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_output("ignore_done_count", done_count, 1);
        check_output("ignore_done_at", done_at, W + 1);
        check_output("ignore_result", {23'd0, carry, soma}, 32'd30);
        check_output("ignore_busy_after", {31'd0, busy}, 32'd0);
        run_op(8'd1, 8'd1, 1'b0, lat, bcyc, bdone);
        check_output("ignore_next_op", {23'd0, carry, soma}, 32'd2);

        // Reset mid-operation
        apply_stimulus(8'd50, 8'd60, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("midrst_soma", {24'd0, soma}, 32'd0);
        check_output("midrst_carry", {31'd0, carry}, 32'd0);
        check_output("midrst_busy", {31'd0, busy}, 32'd0);
        done_count = 0;
        for (int k = 0; k < 15; k++) begin
            if (done) done_count++;
            @(negedge clk);
        end
        check_output("midrst_no_done", done_count, 0);
        run_op(8'd100, 8'd27, 1'b0, lat, bcyc, bdone);
        check_output("midrst_next_op", {23'd0, carry, soma}, 32'd127);

        // Randomized operands with start held high
        @(negedge clk);
        r_a     = W'($urandom_range(0, (1 << W) - 1));
        r_b     = W'($urandom_range(0, (1 << W) - 1));
        r_c     = 1'($urandom_range(0, 1));
        a_in    = r_a;
        b_in    = r_b;
        cin_in  = r_c;
        start   = 1'b1;
        exp_val = ref_sum(int'(r_a), int'(r_b), int'(r_c));
        for (int op = 0; op < 200; op++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!done && gap < 40);
            check_output("rand_done_seen", {31'd0, done}, 32'd1);
            check_output("rand_spacing", gap, (op == 0) ? (W + 1) : (W + 2));
            check_output("rand_result", {23'd0, carry, soma}, exp_val);
            r_a     = W'($urandom_range(0, (1 << W) - 1));
            r_b     = W'($urandom_range(0, (1 << W) - 1));
            r_c     = 1'($urandom_range(0, 1));
            a_in    = r_a;
            b_in    = r_b;
            cin_in  = r_c;
            exp_val = ref_sum(int'(r_a), int'(r_b), int'(r_c));
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
